axi4_stream_byte_strip: RTL
===========================

Name: axi4_stream_byte_strip

Overview:
- Inverse of the stream byte shifter: removes `drop_i` leading bytes from the first beat of each AXI4-Stream packet.
- Realigns the rest of the packet so output byte 0 of beat 0 is input byte `drop_i` of beat 0. Output `tkeep` is low-contiguous.
- Sits on the RX side of header-stripping datapaths, for example after a protocol parser, before the payload FIFO.
- The output packet may be one beat shorter than the input packet.

Parameters:
- DATA_WIDTH, 32, tdata width in bits, multiple of 8.
- ID_WIDTH, 1, tid width.
- DEST_WIDTH, 1, tdest width.
- USER_WIDTH, 1, tuser width.
- DATA_WIDTH_B, DATA_WIDTH/8, bytes per beat.
- DATA_WIDTH_B_W, $clog2(DATA_WIDTH_B), width of the drop value.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- drop_i  in  DATA_WIDTH_B_W  leading bytes to discard; sampled on the first-beat handshake only.
- pkt_i  axi4_stream_if slave  DATA_WIDTH/ID/DEST/USER  input stream.
- pkt_o  axi4_stream_if master  same  output stream.
- pkt_dropped_o  out  1  one-cycle pulse when an entire packet is consumed by the strip.

Behaviour:
- Byte count of a beat = index of the leftmost 1 in tkeep, plus 1.
- Non-last input beats must have all-ones tkeep.
- Registers: hold_data, hold_keep, hold_bytes, drop_lock, tid/tuser/tdest, state.
- tid/tuser/tdest are latched on the first-beat handshake and held for the whole output packet.
- First-beat handshake = pkt_i handshake in IDLE or FLUSH. On it:
  - drop_lock <= drop_i.
  - The beat is loaded into hold.
- Let D = drop_lock, W = DATA_WIDTH_B.
- IDLE:
  - pkt_i.tready=1, pkt_o.tvalid=0.
  - On first beat with tlast and bytes<=drop_i: discard the beat, pulse pkt_dropped_o, stay in IDLE.
  - On first beat with tlast and bytes>drop_i: go to FLUSH.
  - On first beat without tlast: go to HOLD.
- HOLD:
  - pkt_o.tvalid = pkt_i.tvalid; pkt_i.tready = pkt_o.tready (combinational path, no extra register).
  - pkt_o.tdata = (hold_data >> 8D) | (pkt_i.tdata << 8(W-D)); tkeep is formed the same way from keeps.
  - Merge case (pkt_i.tlast and in_bytes<=D): pkt_o.tlast=1, tkeep = low (W-D+in_bytes) bits. Handshake → IDLE; the input beat is fully consumed.
  - Otherwise pkt_o.tlast=0 and tkeep is all ones. Handshake loads hold <= input beat, then → FLUSH if pkt_i.tlast, else stay in HOLD.
  - D=0 never merges: output equals hold, one-beat lag.
- FLUSH:
  - pkt_o.tvalid=1, tlast=1.
  - tdata = hold_data >> 8D; tkeep = low (hold_bytes-D) bits.
  - pkt_i.tready = pkt_o.tready.
  - On output handshake, a simultaneously valid pkt_i beat is taken as the next packet's first beat and follows the IDLE rules. Otherwise → IDLE.
- tstrb is handled identically to tkeep.
- Latency:
  - The first output beat is valid in the same cycle the second input beat is valid.
  - For single-beat packets, it is valid one cycle after acceptance.
- Backpressure: while pkt_o.tvalid && !pkt_o.tready, all pkt_o fields stay stable.
- drop_i changes mid-packet are ignored.
- Shift amounts use width DATA_WIDTH_B_W+1. Byte arithmetic is unsigned with no wrap: D ≤ W-1 and hold_bytes > D are guaranteed by the FSM.
- Reset, including mid-packet:
  - state=IDLE; hold, drop_lock, tid/tuser/tdest = 0.
  - pkt_o.tvalid=0, pkt_dropped_o=0.
  - The partial packet is lost; the next pkt_i beat is treated as a first beat.

Decomposition:
- Package axi4_stream_byte_strip_pkg holds:
  - the state enum {IDLE, HOLD, FLUSH};
  - the function that converts a byte count to a low-contiguous keep mask.
- Sub-module axi4_stream_keep_cnt: combinational leftmost-one byte counter, instantiated for pkt_i.tkeep. Reusable by the shifter.

Test Plan:
All scenarios use DATA_WIDTH=32; bytes are listed from byte 0 upward.
- drop=0, 3-beat packet, last tkeep 4'b0011 → identical 3-beat output, last tkeep 4'b0011, one-beat lag.
- drop=1, beats {00..03},{04..07} full keep → out {01,02,03,04} keep 4'hF, then {05,06,07} keep 4'b0111 tlast.
- drop=2, beats {00..03},{04,05} keep 4'b0011 → single out beat {02,03,04,05} keep 4'hF tlast; packet shrinks by one beat.
- drop=3, single beat keep 4'b0111 → no pkt_o beat; pkt_dropped_o pulses once. drop=3 with keep 4'hF → out {03} keep 4'b0001 tlast.
- drop=1, 4-beat packet, pkt_o.tready low for 3 cycles mid-packet → pkt_i.tready low and pkt_o stable; byte order intact.
- Back-to-back packets with drop 2 then 0, drop_i toggling mid-packet, then rst_i asserted mid-packet → correct per-packet drop; after reset tvalid=0 and the next packet is processed cleanly.

Source files
------------

// File: rtl/axi4_stream_byte_strip_pkg.sv
// -----------------------------------------------------------------------------
// axi4_stream_byte_strip_pkg
// Shared types and helpers for the AXI4-Stream byte strip datapath.
//   state_t    : strip FSM states (IDLE, HOLD, FLUSH)
//   keep_mask  : converts a byte count into a low-contiguous keep mask
// No ports (package).
// -----------------------------------------------------------------------------
package axi4_stream_byte_strip_pkg;

  // Widest beat the keep helper supports (512-bit tdata) and the width of
  // the byte count it accepts.
  localparam int KEEP_MAX_B = 64;
  localparam int KEEP_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Bits [count-1:0] set, everything above cleared. Callers keep the low
  // DATA_WIDTH_B bits of the result.
  function automatic logic [KEEP_MAX_B-1:0] keep_mask(input logic [KEEP_CNT_W-1:0] count);
    logic [KEEP_MAX_B-1:0] mask;
    mask = '0;
    for (int i = 0; i < KEEP_MAX_B; i++) begin
      mask[i] = (i < int'(count));
    end
    return mask;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// -----------------------------------------------------------------------------
// axi4_stream_if
// Minimal AXI4-Stream bundle with master/slave modports.
//   tdata/tkeep/tstrb/tlast/tid/tdest/tuser/tvalid : master -> slave
//   tready                                         : slave -> master
// -----------------------------------------------------------------------------
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [KEEP_WIDTH-1:0] tstrb;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid,
    output tready
  );
endinterface

// File: rtl/axi4_stream_keep_cnt.sv
// -----------------------------------------------------------------------------
// axi4_stream_keep_cnt
// Combinational byte counter: count = index of the leftmost set keep bit + 1
// (0 when keep is all zeros).
//   keep  : in  [KEEP_WIDTH-1:0]   tkeep of a beat
//   count : out [COUNT_WIDTH-1:0]  number of valid bytes
// -----------------------------------------------------------------------------
module axi4_stream_keep_cnt #(
  parameter int KEEP_WIDTH  = 4,
  parameter int COUNT_WIDTH = $clog2(KEEP_WIDTH) + 1
) (
  input  logic [KEEP_WIDTH-1:0]  keep,
  output logic [COUNT_WIDTH-1:0] count
);

  // Later iterations overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    count = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (keep[i]) begin
        count = COUNT_WIDTH'(i + 1);
      end
    end
  end

endmodule

// File: rtl/axi4_stream_byte_strip.sv
// -----------------------------------------------------------------------------
// axi4_stream_byte_strip
// Removes drop_i leading bytes from the first beat of every AXI4-Stream
// packet and realigns the remainder so output keep stays low-contiguous.
// The output packet may be one beat shorter than the input packet; a packet
// with no bytes left after stripping is swallowed and flagged.
//   clk_i         : in   clock
//   rst_i         : in   synchronous active-high reset
//   drop_i        : in   bytes to discard, sampled on a packet's first beat
//   pkt_i         : slave  AXI4-Stream input
//   pkt_o         : master AXI4-Stream output
//   pkt_dropped_o : out  one-cycle pulse when a whole packet was stripped
// -----------------------------------------------------------------------------
module axi4_stream_byte_strip
  import axi4_stream_byte_strip_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 1,
  parameter int DEST_WIDTH     = 1,
  parameter int USER_WIDTH     = 1,
  parameter int DATA_WIDTH_B   = DATA_WIDTH / 8,
  parameter int DATA_WIDTH_B_W = $clog2(DATA_WIDTH_B)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DATA_WIDTH_B_W-1:0] drop_i,
  axi4_stream_if.slave              pkt_i,
  axi4_stream_if.master             pkt_o,
  output logic                      pkt_dropped_o
);

  localparam int W  = DATA_WIDTH_B;
  localparam int CW = DATA_WIDTH_B_W + 1;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0]     hold_data;
  logic [W-1:0]              hold_keep;
  logic [W-1:0]              hold_strb;
  logic [CW-1:0]             hold_bytes;
  logic [DATA_WIDTH_B_W-1:0] drop_lock;
  logic [ID_WIDTH-1:0]       id_lock;
  logic [DEST_WIDTH-1:0]     dest_lock;
  logic [USER_WIDTH-1:0]     user_lock;
  logic                      dropped_q;

  logic [CW-1:0] in_bytes;
  logic [CW-1:0] inv_shift;
  logic [CW-1:0] merge_bytes;
  logic [CW-1:0] flush_bytes;

  logic [DATA_WIDTH-1:0] hold_data_sh;
  logic [DATA_WIDTH-1:0] in_data_sh;
  logic [W-1:0]          hold_keep_sh;
  logic [W-1:0]          in_keep_sh;
  logic [W-1:0]          hold_strb_sh;
  logic [W-1:0]          in_strb_sh;

  logic [KEEP_MAX_B-1:0] merge_mask_full;
  logic [KEEP_MAX_B-1:0] flush_mask_full;
  logic [W-1:0]          merge_mask;
  logic [W-1:0]          flush_mask;

  logic                  in_ready;
  logic                  out_valid;
  logic                  out_last;
  logic [DATA_WIDTH-1:0] out_data;
  logic [W-1:0]          out_keep;
  logic [W-1:0]          out_strb;
  logic                  load_hold;
  logic                  first_beat;
  logic                  drop_pulse;
  logic                  merge;

  axi4_stream_keep_cnt #(
    .KEEP_WIDTH  (W),
    .COUNT_WIDTH (CW)
  ) u_keep_cnt (
    .keep  (pkt_i.tkeep),
    .count (in_bytes)
  );

  // Held beat slides down by D bytes; the incoming beat fills the top D
  // bytes. With D=0 the incoming shift is a full beat width, which yields 0.
  assign inv_shift    = CW'(W) - CW'(drop_lock);
  assign hold_data_sh = hold_data >> {drop_lock, 3'b000};
  assign in_data_sh   = pkt_i.tdata << {inv_shift, 3'b000};
  assign hold_keep_sh = hold_keep >> drop_lock;
  assign in_keep_sh   = pkt_i.tkeep << inv_shift;
  assign hold_strb_sh = hold_strb >> drop_lock;
  assign in_strb_sh   = pkt_i.tstrb << inv_shift;

  // Merge count is W-D+in_bytes, never above W because in_bytes <= D there.
  assign merge_bytes     = CW'(W) - CW'(drop_lock) + in_bytes;
  assign flush_bytes     = hold_bytes - CW'(drop_lock);
  assign merge_mask_full = keep_mask(KEEP_CNT_W'(merge_bytes));
  assign flush_mask_full = keep_mask(KEEP_CNT_W'(flush_bytes));
  assign merge_mask      = merge_mask_full[W-1:0];
  assign flush_mask      = flush_mask_full[W-1:0];

  assign merge = pkt_i.tlast && (in_bytes <= CW'(drop_lock));

  // Next-state and output decode. In HOLD and FLUSH the input ready is the
  // output ready, so the output never needs its own skid register.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = hold_data_sh;
    out_keep   = '0;
    out_strb   = '0;
    load_hold  = 1'b0;
    first_beat = 1'b0;
    drop_pulse = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (pkt_i.tvalid) begin
          first_beat = 1'b1;
        end
      end

      HOLD: begin
        out_valid = pkt_i.tvalid;
        in_ready  = pkt_o.tready;
        out_data  = hold_data_sh | in_data_sh;
        if (merge) begin
          out_last = 1'b1;
          out_keep = (hold_keep_sh | in_keep_sh) & merge_mask;
          out_strb = (hold_strb_sh | in_strb_sh) & merge_mask;
          if (pkt_i.tvalid && pkt_o.tready) begin
            state_next = IDLE;
          end
        end else begin
          out_keep = hold_keep_sh | in_keep_sh;
          out_strb = hold_strb_sh | in_strb_sh;
          if (pkt_i.tvalid && pkt_o.tready) begin
            load_hold  = 1'b1;
            state_next = pkt_i.tlast ? FLUSH : HOLD;
          end
        end
      end

      FLUSH: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_keep  = hold_keep_sh & flush_mask;
        out_strb  = hold_strb_sh & flush_mask;
        in_ready  = pkt_o.tready;
        if (pkt_o.tready) begin
          if (pkt_i.tvalid) begin
            first_beat = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // A first beat whose bytes all fall inside the strip region never
    // produces output; it is flagged and the FSM waits for the next packet.
    if (first_beat) begin
      load_hold = 1'b1;
      if (pkt_i.tlast && (in_bytes <= CW'(drop_i))) begin
        drop_pulse = 1'b1;
        state_next = IDLE;
      end else if (pkt_i.tlast) begin
        state_next = FLUSH;
      end else begin
        state_next = HOLD;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      hold_data  <= '0;
      hold_keep  <= '0;
      hold_strb  <= '0;
      hold_bytes <= '0;
      drop_lock  <= '0;
      id_lock    <= '0;
      dest_lock  <= '0;
      user_lock  <= '0;
      dropped_q  <= 1'b0;
    end else begin
      state     <= state_next;
      dropped_q <= drop_pulse;
      if (load_hold) begin
        hold_data  <= pkt_i.tdata;
        hold_keep  <= pkt_i.tkeep;
        hold_strb  <= pkt_i.tstrb;
        hold_bytes <= in_bytes;
      end
      if (first_beat) begin
        drop_lock <= drop_i;
        id_lock   <= pkt_i.tid;
        dest_lock <= pkt_i.tdest;
        user_lock <= pkt_i.tuser;
      end
    end
  end

  assign pkt_i.tready  = in_ready;
  assign pkt_o.tvalid  = out_valid;
  assign pkt_o.tdata   = out_data;
  assign pkt_o.tkeep   = out_keep;
  assign pkt_o.tstrb   = out_strb;
  assign pkt_o.tlast   = out_last;
  assign pkt_o.tid     = id_lock;
  assign pkt_o.tdest   = dest_lock;
  assign pkt_o.tuser   = user_lock;
  assign pkt_dropped_o = dropped_q;

endmodule
